lsu_mem_port: RTL and testbench

Load/store memory port for the multicycle RV32I core. Sits directly downstream of the controller's MEMORY_READ / MEMORY_WRITE states and upstream of a variable-latency data memory. Turns a one-cycle access request into a ready/valid memory transaction with byte-lane steering, load sign/zero extension, misalignment checking and a wait-state timeout. The controller holds in its memory state while `busy` is high.

---
 rtl/lsu_mem_port.sv | 152 +++++++++++++++
 tb/tb_lsu_mem_port.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store memory port: turns a one-cycle load/store request into a
// ready/valid memory transaction with lane steering, extension and timeout.
module lsu_mem_port #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        f3_ok;
    logic        align_ok;
    logic        req_ok;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] lane_shift;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    // Request legality, byte enables and replicated store data, from the live request.
    always_comb begin
        f3_ok      = 1'b0;
        align_ok   = 1'b0;
        be_next    = 4'b1111;
        wdata_next = wdata;
        if (req_read)
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        else
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        case (funct3[1:0])
            2'b00: begin
                align_ok   = 1'b1;
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                align_ok   = ~addr[0];
                be_next    = 4'b0011 << {addr[1], 1'b0};
                wdata_next = {2{wdata[15:0]}};
            end
            2'b10: begin
                align_ok   = (addr[1:0] == 2'b00);
                be_next    = 4'b1111;
                wdata_next = wdata;
            end
            default: align_ok = 1'b0;
        endcase
        req_ok = (req_read ^ req_write) && f3_ok && align_ok;
    end

    // Lane extraction uses the latched offset/funct3, never the live request.
    always_comb begin
        lane_shift = mem_rdata >> {off_q, 3'b000};
        half_sel   = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{lane_shift[7]}}, lane_shift[7:0]};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'd0, lane_shift[7:0]};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            rdata     <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_read || req_write) begin
                        if (req_ok) begin
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_we    <= req_write;
                            mem_be    <= be_next;
                            mem_wdata <= wdata_next;
                            f3_q      <= funct3;
                            off_q     <= addr[1:0];
                            wait_cnt  <= 8'd0;
                            mem_valid <= 1'b1;
                            busy      <= 1'b1;
                            state     <= REQ;
                        end else begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!mem_we)
                            rdata <= load_val;
                        mem_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        mem_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed self-checking bench for lsu_mem_port: loads, stores, errors,
// back-to-back issue, timeout and asynchronous reset mid-transaction.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_read;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    lsu_mem_port #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_read  (req_read),
        .req_write (req_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_read = 0; req_write = 0; funct3 = 0; addr = 0; wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        #3;
        n_checks++;
        if ({rdata, busy, done, err, mem_valid, mem_we, mem_addr, mem_be, mem_wdata} !== 105'd0)
            $display("FAIL reset_outputs got rdata=%h busy=%b done=%b err=%b valid=%b we=%b addr=%h be=%b wdata=%h want all 0",
                     rdata, busy, done, err, mem_valid, mem_we, mem_addr, mem_be, mem_wdata);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        step();
        n_checks++;
        if ({busy, done, err, mem_valid} !== 4'b0000)
            $display("FAIL reset_idle got %b want 0000", {busy, done, err, mem_valid});
        else n_pass++;
    endtask

    task automatic test_lb_lbu();
        for (int i = 0; i < 2; i++) begin
            logic [31:0] exp_rd;
            exp_rd    = (i == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
            funct3    = (i == 0) ? 3'b000 : 3'b100;
            addr      = 32'h0000_0103;
            mem_rdata = 32'h80FF_0011;
            mem_ready = 1'b1;
            req_read  = 1'b1;
            step();
            req_read = 1'b0;
            n_checks++;
            if ({busy, done, err, mem_valid, mem_we, mem_addr, mem_be} !== {5'b10010, 32'h100, 4'b1000})
                $display("FAIL lb_req[%0d] got st=%b addr=%h be=%b want st=10010 addr=100 be=1000",
                         i, {busy, done, err, mem_valid, mem_we}, mem_addr, mem_be);
            else n_pass++;
            step();
            n_checks++;
            if ({busy, done, err, mem_valid, rdata} !== {4'b0100, exp_rd})
                $display("FAIL lb_done[%0d] got st=%b rdata=%h want st=0100 rdata=%h",
                         i, {busy, done, err, mem_valid}, rdata, exp_rd);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_sh_wait();
        funct3    = 3'b001;
        addr      = 32'h0000_0206;
        wdata     = 32'h1234_ABCD;
        mem_ready = 1'b0;
        req_write = 1'b1;
        step();
        req_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({busy, done, err, mem_valid, mem_we, mem_addr, mem_be, mem_wdata} !==
                {5'b10011, 32'h204, 4'b1100, 32'hABCD_ABCD})
                $display("FAIL sh_wait[%0d] got st=%b addr=%h be=%b wdata=%h want st=10011 addr=204 be=1100 wdata=abcdabcd",
                         i, {busy, done, err, mem_valid, mem_we}, mem_addr, mem_be, mem_wdata);
            else n_pass++;
            if (i < 3) step();
        end
        mem_ready = 1'b1;
        step();
        n_checks++;
        if ({busy, done, err, mem_valid, rdata} !== {4'b0100, 32'h0000_0080})
            $display("FAIL sh_done got st=%b rdata=%h want st=0100 rdata=00000080",
                     {busy, done, err, mem_valid}, rdata);
        else n_pass++;
        step();
    endtask

    task automatic test_sb_sw();
        mem_ready = 1'b1;
        funct3 = 3'b000; addr = 32'h0000_0041; wdata = 32'h1234_565A; req_write = 1'b1;
        step();
        req_write = 1'b0;
        n_checks++;
        if ({mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h40, 4'b0010, 32'h5A5A_5A5A})
            $display("FAIL sb_req got we=%b addr=%h be=%b wdata=%h want we=1 addr=40 be=0010 wdata=5a5a5a5a",
                     mem_we, mem_addr, mem_be, mem_wdata);
        else n_pass++;
        step();
        step();
        funct3 = 3'b010; addr = 32'h0000_0044; wdata = 32'hDEAD_BEEF; req_write = 1'b1;
        step();
        req_write = 1'b0;
        n_checks++;
        if ({mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'h44, 4'b1111, 32'hDEAD_BEEF})
            $display("FAIL sw_req got we=%b addr=%h be=%b wdata=%h want we=1 addr=44 be=1111 wdata=deadbeef",
                     mem_we, mem_addr, mem_be, mem_wdata);
        else n_pass++;
        step();
        n_checks++;
        if ({done, rdata} !== {1'b1, 32'h0000_0080})
            $display("FAIL sw_done got done=%b rdata=%h want done=1 rdata=00000080", done, rdata);
        else n_pass++;
        step();
    endtask

    task automatic test_errors();
        logic [2:0]  f3s [5]   = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010};
        logic [31:0] addrs [5] = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h100};
        logic [1:0]  kinds [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            funct3 = f3s[i];
            addr   = addrs[i];
            {req_read, req_write} = kinds[i];
            step();
            req_read = 1'b0; req_write = 1'b0;
            n_checks++;
            if ({busy, done, err, mem_valid} !== 4'b0110)
                $display("FAIL err_pulse[%0d] got %b want 0110", i, {busy, done, err, mem_valid});
            else n_pass++;
            step();
            n_checks++;
            if ({busy, done, err, mem_valid} !== 4'b0000)
                $display("FAIL err_after[%0d] got %b want 0000", i, {busy, done, err, mem_valid});
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b1;
        funct3 = 3'b010; addr = 32'h100; mem_rdata = 32'hCAFE_F00D; req_read = 1'b1;
        step();
        req_read = 1'b0;
        n_checks++;
        if ({busy, done, err, mem_valid, mem_be} !== {4'b1001, 4'b1111})
            $display("FAIL b2b_lw_req got st=%b be=%b want 1001 1111", {busy, done, err, mem_valid}, mem_be);
        else n_pass++;
        step();
        n_checks++;
        if ({done, rdata} !== {1'b1, 32'hCAFE_F00D})
            $display("FAIL b2b_lw_done got done=%b rdata=%h want 1 cafef00d", done, rdata);
        else n_pass++;
        funct3 = 3'b001; addr = 32'h102; mem_rdata = 32'h8001_1234; req_read = 1'b1;
        step();
        n_checks++;
        if ({busy, done, err, mem_valid} !== 4'b0000)
            $display("FAIL b2b_done_ignores got %b want 0000", {busy, done, err, mem_valid});
        else n_pass++;
        step();
        req_read = 1'b0;
        n_checks++;
        if ({busy, mem_valid, mem_addr, mem_be} !== {2'b11, 32'h100, 4'b1100})
            $display("FAIL b2b_lh_req got bv=%b addr=%h be=%b want 11 100 1100",
                     {busy, mem_valid}, mem_addr, mem_be);
        else n_pass++;
        step();
        n_checks++;
        if ({done, rdata} !== {1'b1, 32'hFFFF_8001})
            $display("FAIL b2b_lh_done got done=%b rdata=%h want 1 ffff8001", done, rdata);
        else n_pass++;
        step();
    endtask

    task automatic test_timeout();
        int cycles = 0;
        int early_done = 0;
        mem_ready = 1'b0;
        funct3 = 3'b010; addr = 32'h300; mem_rdata = 32'h1111_1111; req_read = 1'b1;
        step();
        req_read = 1'b0;
        while (mem_valid === 1'b1 && cycles < 40) begin
            cycles++;
            if (done !== 1'b0) early_done++;
            step();
        end
        n_checks++;
        if (cycles != 15 || early_done != 0)
            $display("FAIL timeout_len got valid_cycles=%0d early_done=%0d want 15 0", cycles, early_done);
        else n_pass++;
        n_checks++;
        if ({busy, done, err, mem_valid, rdata} !== {4'b0110, 32'hFFFF_8001})
            $display("FAIL timeout_done got st=%b rdata=%h want 0110 ffff8001",
                     {busy, done, err, mem_valid}, rdata);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        funct3 = 3'b010; addr = 32'h100; req_read = 1'b1;
        step();
        req_read = 1'b0;
        n_checks++;
        if ({busy, mem_valid} !== 2'b11)
            $display("FAIL rst_mid_req got %b want 11", {busy, mem_valid});
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({mem_valid, busy, done, rdata} !== 35'd0)
            $display("FAIL rst_mid_async got valid=%b busy=%b done=%b rdata=%h want 0",
                     mem_valid, busy, done, rdata);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        step();
        n_checks++;
        if ({busy, done, err, mem_valid} !== 4'b0000)
            $display("FAIL rst_mid_nodone got %b want 0000", {busy, done, err, mem_valid});
        else n_pass++;
        funct3 = 3'b101; addr = 32'h002; mem_rdata = 32'hBEEF_0000; mem_ready = 1'b1; req_read = 1'b1;
        step();
        req_read = 1'b0;
        n_checks++;
        if ({mem_valid, mem_addr, mem_be} !== {1'b1, 32'h0, 4'b1100})
            $display("FAIL lhu_req got valid=%b addr=%h be=%b want 1 0 1100", mem_valid, mem_addr, mem_be);
        else n_pass++;
        step();
        n_checks++;
        if ({done, rdata} !== {1'b1, 32'h0000_BEEF})
            $display("FAIL lhu_done got done=%b rdata=%h want 1 0000beef", done, rdata);
        else n_pass++;
        step();
    endtask

    initial begin
        test_reset();
        test_lb_lbu();
        test_sh_wait();
        test_sb_sw();
        test_errors();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
